alu_cmd_driver: RTL and testbench

Upstream command stage for the serial-opcode ALU controller. Accepts one parallel ALU request (2-bit opcode, operands A and B) over a valid/ready handshake. Serializes it onto the ALU's three-cycle `opcode_valid`/`opcode`/`data` protocol, then waits for the ALU's `done` pulse. Returns result, overflow and a timeout flag over a valid/ready response handshake.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_cmd_driver.sv | 121 ++++++++++++
 tb/tb_alu_cmd_driver.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial-opcode ALU and its upstream command driver.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PAR  = 2'b10;
  localparam logic [1:0] OP_COMP = 2'b11;

  // Number of cycles opcode_valid stays high for one ALU command.
  localparam int unsigned ALU_PROTO_LEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP0,
    ST_SEND_OP1,
    ST_SEND_B,
    ST_WAIT_DONE,
    ST_RESP
  } drv_state_e;

endpackage

// File: rtl/alu_cmd_driver.sv
// Accepts a parallel ALU request, serializes it onto the ALU's three-cycle
// opcode/data protocol, waits for done (or timeout) and returns the response.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_opcode,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  alu_opcode_valid,
  output logic                  alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  alu_done,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  drv_state_e            state;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  ovf_q;
  logic                  tmo_q;
  logic [CNT_W-1:0]      cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q  <= req_opcode;
            a_q   <= req_a;
            b_q   <= req_b;
            state <= ST_SEND_OP0;
          end
        end
        ST_SEND_OP0: state <= ST_SEND_OP1;
        ST_SEND_OP1: state <= ST_SEND_B;
        ST_SEND_B: begin
          cnt   <= '0;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // done takes priority over a timeout expiring in the same cycle
          if (alu_done) begin
            res_q <= alu_result;
            ovf_q <= alu_overflow;
            tmo_q <= 1'b0;
            state <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            tmo_q <= 1'b1;
            state <= ST_RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready        = 1'b0;
    alu_opcode_valid = 1'b0;
    alu_opcode       = 1'b0;
    alu_data         = '0;
    rsp_valid        = 1'b0;
    case (state)
      ST_IDLE:     req_ready = 1'b1;
      ST_SEND_OP0: begin
        alu_opcode_valid = 1'b1;
        alu_opcode       = op_q[0];
      end
      ST_SEND_OP1: begin
        alu_opcode_valid = 1'b1;
        alu_opcode       = op_q[1];
        alu_data         = a_q;
      end
      ST_SEND_B: begin
        alu_opcode_valid = 1'b1;
        alu_data         = b_q;
      end
      ST_RESP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_timeout  = tmo_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed self-checking bench for alu_cmd_driver with a hand-driven ALU side.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_opcode;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          alu_opcode_valid;
  logic          alu_opcode;
  logic [DW-1:0] alu_data;
  logic          alu_done;
  logic [DW-1:0] alu_result;
  logic          alu_overflow;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_overflow;
  logic          rsp_timeout;

  int n_cmp = 0;
  int n_err = 0;

  alu_cmd_driver #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode_valid(alu_opcode_valid), .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_done(alu_done), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at the negedge of SEND_OP0; returns at the negedge of SEND_B.
  task automatic bus_checks(input string tag, input logic [1:0] op,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid = 1'b0;
    chk({tag, " op0 valid"}, alu_opcode_valid, 1'b1);
    chk({tag, " op0 bit"},   alu_opcode, op[0]);
    chk({tag, " op0 data"},  alu_data, '0);
    chk({tag, " op0 ready"}, req_ready, 1'b0);
    tick();
    chk({tag, " op1 valid"}, alu_opcode_valid, 1'b1);
    chk({tag, " op1 bit"},   alu_opcode, op[1]);
    chk({tag, " op1 data"},  alu_data, a);
    tick();
    chk({tag, " b valid"},   alu_opcode_valid, 1'b1);
    chk({tag, " b bit"},     alu_opcode, 1'b0);
    chk({tag, " b data"},    alu_data, b);
  endtask

  task automatic issue(input string tag, input logic [1:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    tick();
    bus_checks(tag, op, a, b);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, " idle ready"}, req_ready, 1'b1);
    chk({tag, " idle rsp_valid"}, rsp_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0;
    alu_done = 1'b0; alu_result = '0; alu_overflow = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst req_ready", req_ready, 1'b1);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst opv", alu_opcode_valid, 1'b0);
    chk("rst opcode", alu_opcode, 1'b0);
    chk("rst data", alu_data, '0);
    chk("rst result", rsp_result, '0);
    chk("rst ovf", rsp_overflow, 1'b0);
    chk("rst tmo", rsp_timeout, 1'b0);
    reset = 1'b0;

    // Spurious done while idle
    tick();
    alu_done = 1'b1; alu_result = 8'hEE; alu_overflow = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("idle done rsp_valid", rsp_valid, 1'b0);
    chk("idle done ready", req_ready, 1'b1);
    chk("idle done result", rsp_result, '0);

    // ADD 5+3, spurious done in SEND_B, real done two cycles after SEND_B
    issue("add", OP_ADD, 8'd5, 8'd3);
    alu_done = 1'b1; alu_result = 8'hEE; alu_overflow = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("add wait rsp_valid", rsp_valid, 1'b0);
    chk("add wait opv", alu_opcode_valid, 1'b0);
    chk("add wait data", alu_data, '0);
    tick();
    chk("add wait2 rsp_valid", rsp_valid, 1'b0);
    alu_done = 1'b1; alu_result = 8'd8; alu_overflow = 1'b0;
    tick();
    alu_done = 1'b0; alu_result = '0;
    chk("add rsp_valid", rsp_valid, 1'b1);
    chk("add result", rsp_result, 8'd8);
    chk("add ovf", rsp_overflow, 1'b0);
    chk("add tmo", rsp_timeout, 1'b0);
    finish_rsp("add");

    // Reset in SEND_OP1, then a clean PAR transaction
    req_opcode = OP_PAR; req_a = 8'h07; req_b = 8'h02; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("par0 opv", alu_opcode_valid, 1'b1);
    tick();
    chk("par1 opv", alu_opcode_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst opv", alu_opcode_valid, 1'b0);
    chk("midrst rsp_valid", rsp_valid, 1'b0);
    chk("midrst ready", req_ready, 1'b1);
    chk("midrst result", rsp_result, '0);
    tick();
    reset = 1'b0;
    issue("par", OP_PAR, 8'h07, 8'h02);
    tick();
    alu_done = 1'b1; alu_result = 8'h05; alu_overflow = 1'b0;
    tick();
    alu_done = 1'b0;
    chk("par rsp_valid", rsp_valid, 1'b1);
    chk("par result", rsp_result, 8'h05);
    chk("par tmo", rsp_timeout, 1'b0);
    finish_rsp("par");

    // SUB with overflow; response held 5 cycles while a COMP request waits
    issue("sub", OP_SUB, 8'h80, 8'h01);
    tick();
    alu_done = 1'b1; alu_result = 8'h7F; alu_overflow = 1'b1;
    req_opcode = OP_COMP; req_a = 8'hA5; req_b = 8'h3C; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      alu_done = 1'b0; alu_result = '0; alu_overflow = 1'b0;
      chk("hold rsp_valid", rsp_valid, 1'b1);
      chk("hold result", rsp_result, 8'h7F);
      chk("hold ovf", rsp_overflow, 1'b1);
      chk("hold tmo", rsp_timeout, 1'b0);
      chk("hold req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("release ready", req_ready, 1'b1);
    chk("release rsp_valid", rsp_valid, 1'b0);
    chk("release opv", alu_opcode_valid, 1'b0);
    tick();
    bus_checks("comp", OP_COMP, 8'hA5, 8'h3C);

    // No done: timeout after exactly TO cycles in WAIT_DONE
    for (int i = 0; i < int'(TO); i++) begin
      tick();
      chk("tmo wait rsp_valid", rsp_valid, 1'b0);
    end
    tick();
    chk("tmo rsp_valid", rsp_valid, 1'b1);
    chk("tmo flag", rsp_timeout, 1'b1);
    chk("tmo result", rsp_result, '0);
    chk("tmo ovf", rsp_overflow, 1'b0);
    finish_rsp("tmo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
